serial_addsub: RTL and testbench

Parametrised bit-serial add/subtract unit, the sequential successor to the single-bit full adder/subtractor cells.
- Latches two WIDTH-bit operands and a mode bit on a start pulse.
- Processes one bit per clock, LSB first, through a one-bit add/sub cell with a registered carry/borrow.
- Reports result, carry-or-borrow out and signed overflow with a done pulse.
- Used where area matters more than latency.

---
 rtl/serial_addsub_pkg.sv | 23 ++
 rtl/addsub_bit_cell.sv | 25 ++
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared encodings and helpers for the bit-serial add/subtract unit.
// Holds the mode and FSM state encodings plus the signed-overflow rule.
package serial_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The result MSB disagreeing with A's sign is only an overflow when the
  // effective operand signs agree (B's sign is flipped by subtraction).
  function automatic logic signed_ovf(input logic mode, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic signs_agree;
    signs_agree = (mode == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
    return signs_agree && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational one-bit add/subtract cell: sum or difference bit plus the
// outgoing carry (add) or borrow (subtract).
module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic cin,
  input  logic mode,
  output logic r,
  output logic cnext
);

  assign r = ai ^ bi ^ cin;

  always_comb begin
    cnext = 1'b0;
    if (mode == MODE_SUB) begin
      cnext = (~ai & bi) | (cin & ~(ai ^ bi));
    end else begin
      cnext = (ai & bi) | (cin & (ai ^ bi));
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: latches operands on start, processes one bit per
// clock LSB first, and publishes result/cout/ovf with a one-cycle done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_r;
  logic             bit_cnext;
  logic [WIDTH-1:0] sh_next;

  addsub_bit_cell u_cell (
    .ai   (a_q[cnt_q]),
    .bi   (b_q[cnt_q]),
    .cin  (c_q),
    .mode (mode_q),
    .r    (bit_r),
    .cnext(bit_cnext)
  );

  // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sh_next = {bit_r, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    result_d = result_q;
    mode_d   = mode_q;
    c_d      = c_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          c_d     = 1'b0;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d = sh_next;
        c_d  = bit_cnext;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = sh_next;
          cout_d   = bit_cnext;
          ovf_d    = signed_ovf(mode_q, a_q[WIDTH-1], b_q[WIDTH-1], bit_r);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8 (directed table, random,
// abort-by-reset) and WIDTH=4 (exhaustive) against an arithmetic model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, mode8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, res8;
  logic       rst4, start4, mode4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, res4;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       o;
    bit         inject;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: modular arithmetic for the result, unsigned compare for
  // carry/borrow, signed range test for overflow.
  function automatic void ref_model(input int w, input logic m, input int x, input int y,
                                    output int r, output int c, output int o);
    int mask, sx, sy, sv;
    mask = (1 << w) - 1;
    if (m) begin
      r = (x - y) & mask;
      c = (x < y) ? 1 : 0;
    end else begin
      r = (x + y) & mask;
      c = ((x + y) > mask) ? 1 : 0;
    end
    sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
    sv = m ? sx - sy : sx + sy;
    o = (sv > (1 << (w - 1)) - 1 || sv < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  // Called at a negedge while idle; returns at the negedge of the IDLE cycle
  // after DONE so a following call is a back-to-back start.
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input bit inject,
                     output logic [7:0] r, output logic c, output logic o);
    logic [7:0] prev;
    int k, nbusy;
    prev   = res8;
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~m;
    k = 0; nbusy = 0;
    while (!done8 && k < 40) begin
      if (busy8) nbusy++;
      if (k == 3) begin
        chk("hold_mid_run", res8, prev);
        if (inject) begin start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; mode8 = 1'b1; end
      end
      if (k == 4) start8 = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, 8);
    chk("busy_cycles", nbusy, 8);
    r = res8; c = cout8; o = ovf8;
    @(negedge clk);
    chk("done_one_cycle", done8, 1'b0);
    chk("idle_not_busy", busy8, 1'b0);
    $display("op8 mode=%0d a=%02h b=%02h -> result=%02h cout=%0d ovf=%0d lat=%0d", m, x, y, r, c, o, k);
  endtask

  task automatic op4(input logic m, input logic [3:0] x, input logic [3:0] y);
    int k, er, ec, eo;
    start4 = 1'b1; mode4 = m; a4 = x; b4 = y;
    @(negedge clk);
    start4 = 1'b0; a4 = ~x; b4 = ~y;
    k = 0;
    while (!done4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ref_model(4, m, int'(x), int'(y), er, ec, eo);
    chk("w4_latency", k, 4);
    chk("w4_result", res4, er);
    chk("w4_cout", cout4, ec);
    chk("w4_ovf", ovf4, eo);
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       c, o;
    int         er, ec, eo;
    logic [7:0] x, y;
    logic       m;
    int         seen;

    vecs[0] = '{1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h15, 8'h3C, 8'hD9, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1};

    rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    rst4 = 1'b1; start4 = 1'b1; mode4 = 1'b0; a4 = 4'h7;  b4 = 4'h3;
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_result8", res8, 8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_ovf8", ovf8, 1'b0);
    chk("rst_busy4_start_held", busy4, 1'b0);
    rst8 = 1'b0; rst4 = 1'b0; start4 = 1'b0;
    @(negedge clk);

    // Directed vectors run back to back: each start lands in the IDLE cycle after DONE.
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].inject, r, c, o);
      chk($sformatf("vec%0d_result", i), r, vecs[i].r);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].c);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].o);
    end

    repeat (3) @(negedge clk);
    chk("hold_in_idle", res8, 8'h30);

    // Abort by reset during RUN cycle 4.
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h0F; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy8, 1'b1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_result", res8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    chk("abort_ovf", ovf8, 1'b0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    op8(1'b1, 8'h05, 8'h07, 1'b0, r, c, o);
    chk("post_rst_result", r, 8'hFE);
    chk("post_rst_cout", c, 1'b1);
    chk("post_rst_ovf", o, 1'b0);

    // Random WIDTH=8 operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom); m = 1'($urandom);
      op8(m, x, y, 1'b0, r, c, o);
      ref_model(8, m, int'(x), int'(y), er, ec, eo);
      chk("rand_result", r, er);
      chk("rand_cout", c, ec);
      chk("rand_ovf", o, eo);
    end

    // Exhaustive WIDTH=4.
    for (int mi = 0; mi < 2; mi++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          op4(1'(mi), 4'(ai), 4'(bi));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
